// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard/stall controller signal bundle.
// master = pipeline side, slave = hazard_stall_ctrl.
interface hazard_stall_ctrl_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic [3:0]  ID_Hazards;
    logic        ID_MulDivRead;
    logic [4:0]  EX_Rw;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic [4:0]  M_Rw;
    logic        M_MemRead;
    logic        M_MemStall;
    logic        EX_MulDivStart;
    logic        EX_IsDiv;
    logic        EX_MulDivAbort;
    logic        IF_Stall;
    logic        ID_Stall;
    logic        EX_Stall;
    logic        M_Stall;
    logic        MulDivBusy;
    logic [31:0] StallCycles;

    modport master (
        output ID_Rs, ID_Rt, ID_Hazards, ID_MulDivRead, EX_Rw, EX_RegWrite,
               EX_MemRead, M_Rw, M_MemRead, M_MemStall, EX_MulDivStart,
               EX_IsDiv, EX_MulDivAbort,
        input  IF_Stall, ID_Stall, EX_Stall, M_Stall, MulDivBusy, StallCycles
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_Hazards, ID_MulDivRead, EX_Rw, EX_RegWrite,
               EX_MemRead, M_Rw, M_MemRead, M_MemStall, EX_MulDivStart,
               EX_IsDiv, EX_MulDivAbort,
        output IF_Stall, ID_Stall, EX_Stall, M_Stall, MulDivBusy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// 5-stage pipe hazard/stall controller with mult/div busy tracking.
// Optional macro HAZARD_PERF_EN builds the ID-stall cycle counter (StallCycles).
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic              CLK,
    input  logic              RST_N,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ID_Hazards = {WantRs, NeedRs, WantRt, NeedRt}
    logic want_rs, need_rs, want_rt, need_rt;
    assign {want_rs, need_rs, want_rt, need_rt} = bus.ID_Hazards;

    // r0 is hardwired zero, so it can never carry a hazard
    logic rs_ex, rt_ex, rs_m, rt_m;
    assign rs_ex = (bus.ID_Rs != 5'd0) && (bus.ID_Rs == bus.EX_Rw);
    assign rt_ex = (bus.ID_Rt != 5'd0) && (bus.ID_Rt == bus.EX_Rw);
    assign rs_m  = (bus.ID_Rs != 5'd0) && (bus.ID_Rs == bus.M_Rw);
    assign rt_m  = (bus.ID_Rt != 5'd0) && (bus.ID_Rt == bus.M_Rw);

    logic busy, load_use, id_alu, id_load, md_rd, md_struct;
    logic m_stall, ex_stall, id_stall;

    assign busy      = (state_q == BUSY);
    assign load_use  = bus.EX_MemRead &
                       ((rs_ex & (want_rs | need_rs)) | (rt_ex & (want_rt | need_rt)));
    assign id_alu    = bus.EX_RegWrite & ((rs_ex & need_rs) | (rt_ex & need_rt));
    assign id_load   = bus.M_MemRead & ((rs_m & need_rs) | (rt_m & need_rt));
    assign md_rd     = bus.ID_MulDivRead & (busy | bus.EX_MulDivStart);
    assign md_struct = bus.EX_MulDivStart & busy;

    // Each stage stall includes all later ones, keeping IF>=ID>=EX>=M
    assign m_stall  = bus.M_MemStall & RST_N;
    assign ex_stall = m_stall | (md_struct & RST_N);
    assign id_stall = ex_stall | ((load_use | id_alu | id_load | md_rd) & RST_N);

    assign bus.M_Stall    = m_stall;
    assign bus.EX_Stall   = ex_stall;
    assign bus.ID_Stall   = id_stall;
    assign bus.IF_Stall   = id_stall;
    assign bus.MulDivBusy = busy;

    // Counter runs free of pipeline stalls; abort wins over any start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.EX_MulDivAbort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.EX_MulDivStart && !ex_stall) begin
                state_d = BUSY;
                cnt_d   = bus.EX_IsDiv ? DIV_LD : MULT_LD;
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    assign perf_d = id_stall ? perf_q + 32'd1 : perf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign bus.StallCycles = perf_q;
`else
    assign bus.StallCycles = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: combinational vector table plus
// hand-written mult/div, memory-stall, abort and reset sequences.
module tb_hazard_stall_ctrl;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd1;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic [3:0] haz;
        logic       mdrd;
        logic [4:0] ex_rw;
        logic       ex_wr, ex_mr;
        logic [4:0] m_rw;
        logic       m_mr, m_st;
        logic [3:0] exp;   // {IF,ID,EX,M}
    } vec_t;

    vec_t tbl[12];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] stalls();
        return {bus.IF_Stall, bus.ID_Stall, bus.EX_Stall, bus.M_Stall};
    endfunction

    task automatic clr();
        bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_Hazards = '0; bus.ID_MulDivRead = 1'b0;
        bus.EX_Rw = '0; bus.EX_RegWrite = 1'b0; bus.EX_MemRead = 1'b0;
        bus.M_Rw = '0; bus.M_MemRead = 1'b0; bus.M_MemStall = 1'b0;
        bus.EX_MulDivStart = 1'b0; bus.EX_IsDiv = 1'b0; bus.EX_MulDivAbort = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.ID_Rs = v.rs; bus.ID_Rt = v.rt; bus.ID_Hazards = v.haz;
        bus.ID_MulDivRead = v.mdrd; bus.EX_Rw = v.ex_rw; bus.EX_RegWrite = v.ex_wr;
        bus.EX_MemRead = v.ex_mr; bus.M_Rw = v.m_rw; bus.M_MemRead = v.m_mr;
        bus.M_MemStall = v.m_st;
    endtask

    task automatic tick(); @(posedge CLK); #1; endtask
    task automatic smp();  @(negedge CLK);     endtask

    int busy_n, stall_n, mis;

    initial begin
        //        name          rs    rt    haz      md  exrw  wr  mr  mrw  mmr mst  exp
        tbl[0]  = '{"idle",     5'd0, 5'd0, 4'b0000, 0, 5'd0, 0, 0, 5'd0, 0, 0, 4'b0000};
        tbl[1]  = '{"lw_use",   5'd5, 5'd1, 4'b1000, 0, 5'd5, 1, 1, 5'd0, 0, 0, 4'b1100};
        tbl[2]  = '{"beq_alu",  5'd7, 5'd2, 4'b0100, 0, 5'd7, 1, 0, 5'd0, 0, 0, 4'b1100};
        tbl[3]  = '{"beq_r0",   5'd0, 5'd2, 4'b0100, 0, 5'd0, 1, 0, 5'd0, 0, 0, 4'b0000};
        tbl[4]  = '{"alu_fwd",  5'd7, 5'd2, 4'b1000, 0, 5'd7, 1, 0, 5'd0, 0, 0, 4'b0000};
        tbl[5]  = '{"lw_rt",    5'd1, 5'd9, 4'b0010, 0, 5'd9, 1, 1, 5'd0, 0, 0, 4'b1100};
        tbl[6]  = '{"m_ld_need",5'd1, 5'd3, 4'b0001, 0, 5'd0, 0, 0, 5'd3, 1, 0, 4'b1100};
        tbl[7]  = '{"m_ld_want",5'd1, 5'd3, 4'b0010, 0, 5'd0, 0, 0, 5'd3, 1, 0, 4'b0000};
        tbl[8]  = '{"memstall", 5'd0, 5'd0, 4'b0000, 0, 5'd0, 0, 0, 5'd0, 0, 1, 4'b1111};
        tbl[9]  = '{"lw_nomatch",5'd6,5'd1, 4'b1000, 0, 5'd5, 1, 1, 5'd0, 0, 0, 4'b0000};
        tbl[10] = '{"mfhi_idle",5'd0, 5'd0, 4'b0000, 1, 5'd0, 0, 0, 5'd0, 0, 0, 4'b0000};
        tbl[11] = '{"lw_r0",    5'd0, 5'd0, 4'b1100, 0, 5'd0, 1, 1, 5'd0, 0, 0, 4'b0000};

        // Reset: stalls forced low even with a memory stall pending
        RST_N = 1'b0;
        clr();
        bus.M_MemStall = 1'b1;
        #12;
        check("rst_stalls", 32'(stalls()), 32'h0);
        check("rst_busy", 32'(bus.MulDivBusy), 32'h0);
        check("rst_perf", bus.StallCycles, 32'h0);
        bus.M_MemStall = 1'b0;
        @(negedge CLK) RST_N = 1'b1;

        // Load-use for one cycle, then perf counter reads 1 if built
        tick(); apply(tbl[1]);
        smp();  check("s1_stall", 32'(stalls()), 32'hC);
        tick(); clr();
        smp();  check("s1_release", 32'(stalls()), 32'h0);
        check("s1_perf", bus.StallCycles, PERF_EXP);

        foreach (tbl[i]) begin
            tick(); apply(tbl[i]);
            smp();  check(tbl[i].name, 32'(stalls()), 32'(tbl[i].exp));
        end
        tick(); clr();

        // Divide: 32 busy cycles, MFLO in ID stalled for each of them
        bus.EX_MulDivStart = 1'b1; bus.EX_IsDiv = 1'b1;
        smp();  check("div_start_ex", 32'(bus.EX_Stall), 32'h0);
        tick(); bus.EX_MulDivStart = 1'b0; bus.EX_IsDiv = 1'b0; bus.ID_MulDivRead = 1'b1;
        busy_n = 0; stall_n = 0; mis = 0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (!bus.MulDivBusy) break;
            busy_n++;
            if (bus.ID_Stall) stall_n++;
            if (bus.IF_Stall !== bus.ID_Stall || bus.EX_Stall !== 1'b0) mis++;
            tick();
        end
        check("div_busy_cycles", busy_n, 32);
        check("mflo_stall_cycles", stall_n, 32);
        check("div_stall_shape", mis, 0);
        check("mflo_released", 32'(stalls()), 32'h0);
        tick(); clr();

        // Mult, second mult arrives with two busy cycles left
        bus.EX_MulDivStart = 1'b1;
        smp();
        tick(); bus.EX_MulDivStart = 1'b0;      // cnt=3
        smp();
        tick();                                  // cnt=2
        smp();
        tick(); bus.EX_MulDivStart = 1'b1;      // cnt=1
        stall_n = 0; mis = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (!bus.EX_Stall) break;
            stall_n++;
            if (bus.ID_Stall !== 1'b1 || bus.IF_Stall !== 1'b1) mis++;
            tick();
        end
        check("mult_struct_cycles", stall_n, 2);
        check("mult_struct_id", mis, 0);
        check("mult_idle_at_accept", 32'(bus.MulDivBusy), 32'h0);
        tick(); bus.EX_MulDivStart = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (!bus.MulDivBusy) break;
            busy_n++;
            tick();
        end
        check("mult2_busy_cycles", busy_n, 4);
        tick(); clr();

        // Memory stall during BUSY: counter keeps running
        bus.EX_MulDivStart = 1'b1;
        smp();
        tick(); bus.EX_MulDivStart = 1'b0; bus.M_MemStall = 1'b1;
        mis = 0;
        for (int i = 0; i < 3; i++) begin
            smp();
            if ({stalls(), bus.MulDivBusy} !== 5'h1F) mis++;
            tick();
        end
        check("memstall_all4", mis, 0);
        bus.M_MemStall = 1'b0;
        smp();  check("memstall_busy_last", 32'(bus.MulDivBusy), 32'h1);
        tick();
        smp();  check("memstall_busy_done", 32'(bus.MulDivBusy), 32'h0);
        tick(); clr();

        // Abort together with a start while BUSY
        bus.EX_MulDivStart = 1'b1; bus.EX_IsDiv = 1'b1;
        smp();
        tick(); bus.EX_MulDivStart = 1'b0;
        smp();
        tick();
        smp();  check("abort_pre_busy", 32'(bus.MulDivBusy), 32'h1);
        tick(); bus.EX_MulDivAbort = 1'b1; bus.EX_MulDivStart = 1'b1;
        smp();  check("abort_cycle_ex", 32'(bus.EX_Stall), 32'h1);
        tick(); bus.EX_MulDivAbort = 1'b0; bus.EX_MulDivStart = 1'b0;
        smp();  check("abort_idle", 32'(bus.MulDivBusy), 32'h0);

        // Async reset mid-divide
        tick(); bus.EX_MulDivStart = 1'b1;
        smp();
        tick(); bus.EX_MulDivStart = 1'b0;
        smp();
        tick();
        smp();  check("rst_mid_pre", 32'(bus.MulDivBusy), 32'h1);
        bus.M_MemStall = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check("rst_mid_busy", 32'(bus.MulDivBusy), 32'h0);
        check("rst_mid_stalls", 32'(stalls()), 32'h0);
        check("rst_mid_perf", bus.StallCycles, 32'h0);
        clr();
        @(negedge CLK) RST_N = 1'b1;
        smp();  check("post_rst_busy", 32'(bus.MulDivBusy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
